// File: rtl/btn_pkg.sv
// btn_pkg: shared types and helpers for the push-button conditioning slice.
//   btn_state_t : press-tracking FSM encoding (IDLE, PRESSED, HELD)
//   cnt_width() : counter width for a terminal count n, never below 1 bit
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PRESSED = 2'b01,
    HELD    = 2'b10
  } btn_state_t;

  // Width of a counter that must hold values 0..n-1; a 1-cycle count still needs a bit.
  function automatic int cnt_width(input int n);
    if ($clog2(n) < 32'sd1) begin
      return 32'sd1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous board input.
// Both flops load RST_VAL on reset so the downstream logic sees the
// chosen idle level until real samples have propagated through.
// Ports:
//   clk  - destination clock
//   rst  - synchronous reset, active-low
//   d    - asynchronous input
//   q    - synchronised output (second flop)
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  // Next-state of the synchroniser chain.
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  // Synchroniser flops with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/btn_debounce.sv
// btn_debounce: synchronises and debounces a raw push-button, then derives
// one-cycle press/release/long-press pulses and a toggled `run` level that
// feeds the blinker's active-low reset/enable.
// Optional feature macro: BTN_DEBOUNCE_LONG_PRESS_EN
//   defined   : HELD state and hold counter present; a long press clears run
//               and its release leaves run alone.
//   undefined : no long-press detection; every release toggles run.
// Ports:
//   clk              - system clock
//   rst              - synchronous reset, active-low
//   btn_in           - raw asynchronous button pin
//   btn_level        - debounced pressed level (1 = pressed)
//   press_pulse      - one cycle when btn_level rises
//   release_pulse    - one cycle when btn_level falls
//   long_press_pulse - one cycle when a long press is detected
//   run              - toggled run level
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int LONG_PRESS_CYCLES = 100_000_000,
  parameter bit ACTIVE_LOW        = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse,
  output logic run
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic sync_s, pressed_s, rise_s, fall_s;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic level_q, level_d;
  logic press_q, press_d;
  logic release_q, release_d;
  logic run_q, run_d;
  btn_state_t state_q, state_d;

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
  localparam int HW = cnt_width(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
  logic [HW-1:0] hold_q, hold_d;
  logic long_q, long_d;
`endif

  sync_2ff #(
    .RST_VAL(ACTIVE_LOW ? 1'b1 : 1'b0)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (btn_in),
    .q  (sync_s)
  );

  // Polarity correction so that 1 always means pressed.
  always_comb begin
    if (ACTIVE_LOW) begin
      pressed_s = ~sync_s;
    end else begin
      pressed_s = sync_s;
    end
  end

  // Debounce counter: only a disagreement held for DEBOUNCE_CYCLES moves the level.
  always_comb begin
    db_cnt_d = db_cnt_q;
    level_d  = level_q;
    if (pressed_s == level_q) begin
      db_cnt_d = {DW{1'b0}};
    end else if (db_cnt_q == DB_LAST) begin
      level_d  = pressed_s;
      db_cnt_d = {DW{1'b0}};
    end else begin
      db_cnt_d = db_cnt_q + DW'(1);
    end
  end

  // Edges are taken from the next level so pulses line up with the new level.
  assign rise_s = level_d & ~level_q;
  assign fall_s = ~level_d & level_q;

  // Press-tracking FSM next-state and pulse/run outputs.
  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    press_d   = rise_s;
    release_d = fall_s;
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
    hold_d    = hold_q;
    long_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (rise_s) begin
          state_d = PRESSED;
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
          hold_d  = {HW{1'b0}};
`endif
        end else begin
          state_d = IDLE;
        end
      end
      PRESSED: begin
        // A release that coincides with the long-press threshold counts as a short press.
        if (fall_s) begin
          state_d = IDLE;
          run_d   = ~run_q;
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
        end else if (hold_q == HOLD_LAST) begin
          state_d = HELD;
          long_d  = 1'b1;
          run_d   = 1'b0;
        end else begin
          hold_d  = hold_q + HW'(1);
`else
        end else begin
`endif
          state_d = PRESSED;
        end
      end
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
      HELD: begin
        // Hold counter is left saturated here; only IDLE->PRESSED reloads it.
        if (fall_s) begin
          state_d = IDLE;
        end else begin
          state_d = HELD;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      db_cnt_q  <= {DW{1'b0}};
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      run_q     <= 1'b0;
      state_q   <= IDLE;
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
      hold_q    <= {HW{1'b0}};
      long_q    <= 1'b0;
`endif
    end else begin
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      run_q     <= run_d;
      state_q   <= state_d;
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
      hold_q    <= hold_d;
      long_q    <= long_d;
`endif
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign run           = run_q;
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
  assign long_press_pulse = long_q;
`else
  assign long_press_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed, table-driven bench for btn_debounce with
// DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16, ACTIVE_LOW=1.
// Each step drives inputs, waits for one rising edge, and compares all
// outputs 1 time unit later against hand-computed expectations.
// Step numbering: the first step that drives a new raw value is step 1;
// its edge is the first sampling edge, so a debounced change appears at step 6.
module tb_btn_debounce;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic btn_level, press_pulse, release_pulse, long_press_pulse, run;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic rst;
    logic btn;
    logic lvl;
    logic pp;
    logic rp;
    logic lp;
    logic run;
  } vec_t;

  vec_t vecs[$];
  int   vec_idx = 0;

  btn_debounce #(
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(16),
    .ACTIVE_LOW       (1'b1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .btn_in          (btn_in),
    .btn_level       (btn_level),
    .press_pulse     (press_pulse),
    .release_pulse   (release_pulse),
    .long_press_pulse(long_press_pulse),
    .run             (run)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%b want=%b", name, vec_idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic b, input logic l, input logic p,
                     input logic rl, input logic lp, input logic rn);
    vec_t v;
    v.rst = r; v.btn = b; v.lvl = l; v.pp = p; v.rp = rl; v.lp = lp; v.run = rn;
    vecs.push_back(v);
  endtask

  // Short press: button low for `hold` steps (hold >= 6), then released for 8 steps.
  task automatic add_press(input int hold, input logic run_before);
    for (int i = 1; i <= hold; i++) begin
      add(1'b1, 1'b0, (i >= 6), (i == 6), 1'b0, 1'b0, run_before);
    end
    for (int j = 1; j <= 8; j++) begin
      add(1'b1, 1'b1, (j < 6), 1'b0, (j == 6), 1'b0, (j >= 6) ? ~run_before : run_before);
    end
  endtask

  task automatic apply_vec(input vec_t v);
    rst    = v.rst;
    btn_in = v.btn;
    @(posedge clk);
    #1;
    vec_idx++;
    chk("btn_level",        btn_level,        v.lvl);
    chk("press_pulse",      press_pulse,      v.pp);
    chk("release_pulse",    release_pulse,    v.rp);
    chk("long_press_pulse", long_press_pulse, v.lp);
    chk("run",              run,              v.run);
  endtask

  task automatic apply_all();
    foreach (vecs[k]) begin
      apply_vec(vecs[k]);
    end
    vecs.delete();
  endtask

  initial begin
    vec_t v;
    logic long_en;
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
    long_en = 1'b1;
`else
    long_en = 1'b0;
`endif
    rst    = 1'b0;
    btn_in = 1'b1;

    // ---- table: reset, idle, two short presses, bounce, near-threshold glitch, third press
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_press(8, 1'b0);   // run 0 -> 1
    add_press(8, 1'b1);   // run 1 -> 0
    // Bounce: 0,0,1,1,... for 20 steps, then released; nothing may change.
    for (int i = 0; i < 20; i++) begin
      add(1'b1, ((i / 2) % 2 == 1) ? 1'b1 : 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 6; i++) add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Glitch one cycle shorter than DEBOUNCE_CYCLES: rejected.
    for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_press(8, 1'b0);   // run 0 -> 1
    apply_all();

    // ---- long press with run=1: held 30 steps, then released 10 steps
    // press_pulse at step 6, long_press_pulse 16 cycles later at step 22,
    // release seen at step 36.
    for (int s = 1; s <= 40; s++) begin
      v.rst = 1'b1;
      v.btn = (s <= 30) ? 1'b0 : 1'b1;
      v.lvl = (s >= 6) && (s < 36);
      v.pp  = (s == 6);
      v.rp  = (s == 36);
      v.lp  = long_en && (s == 22);
      if (long_en) v.run = (s < 22);
      else         v.run = (s < 36);
      apply_vec(v);
    end

    // ---- short press to bring run back to 1, then reset mid-press
    add_press(8, 1'b0);
    apply_all();
    for (int i = 1; i <= 8; i++) begin
      add(1'b1, 1'b0, (i >= 6), (i == 6), 1'b0, 1'b0, 1'b1);
    end
    apply_all();
    // Reset with the button still held: everything, including run, clears.
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Counting the reset edge as edge 1, press_pulse appears after edge 7.
    for (int i = 1; i <= 7; i++) begin
      add(1'b1, 1'b0, (i >= 6), (i == 6), 1'b0, 1'b0, 1'b0);
    end
    // FSM restarted from IDLE, so this release is a short press: run 0 -> 1.
    for (int j = 1; j <= 8; j++) begin
      add(1'b1, 1'b1, (j < 6), 1'b0, (j == 6), 1'b0, (j >= 6));
    end
    apply_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
Upstream conditioning stage for the board LED blinker. It synchronises and debounces a raw push-button, then produces a clean level, one-cycle press/release/long-press pulses, and a toggled `run` level. `run` drives the blinker's active-low synchronous reset/enable input: `run`=1 lets the blinker count, `run`=0 holds it cleared.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, cycles the synchronised input must be stable before `btn_level` changes (10 ms at 100 MHz); legal range ≥2.
LONG_PRESS_CYCLES, 100_000_000, cycles `btn_level` must stay pressed before a long press is declared (1 s); must be > DEBOUNCE_CYCLES.
ACTIVE_LOW, 1, 1: a raw 0 on `btn_in` means pressed; 0: a raw 1 means pressed.

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  synchronous reset, active-low; clock is clk
btn_in  input  1  raw asynchronous button pin
btn_level  output  1  debounced pressed level, 1 = pressed
press_pulse  output  1  one-cycle pulse when `btn_level` rises
release_pulse  output  1  one-cycle pulse when `btn_level` falls
long_press_pulse  output  1  one-cycle pulse when a long press is detected
run  output  1  toggled run level; feeds the blinker reset/enable

Behaviour:
- Reset (`rst`=0 sampled on posedge clk):
  - both synchroniser flops load the inactive raw level (ACTIVE_LOW ? 1 : 0);
  - counters clear to 0; FSM goes to IDLE;
  - all outputs go to 0, including `run`.
- Synchroniser: 2-FF chain on `btn_in`. `pressed_s` = second flop, polarity-corrected by ACTIVE_LOW.
- Debounce counter, width $clog2(DEBOUNCE_CYCLES):
  - if `pressed_s` == `btn_level`: counter <= 0;
  - else if counter == DEBOUNCE_CYCLES-1: `btn_level` <= `pressed_s`, counter <= 0;
  - else counter <= counter+1.
- Latency: `btn_level` changes exactly DEBOUNCE_CYCLES+1 edges after the edge that first samples a stable new raw value.
- Glitch rejection: any bounce shorter than DEBOUNCE_CYCLES returns the counter to 0, with no output change.
- Pulses are registered and high only in the first cycle `btn_level` shows its new value. `press_pulse` and `release_pulse` are never high together.
- FSM states: IDLE, PRESSED, HELD.
  - IDLE -> PRESSED on `btn_level` rise. `press_pulse` fires; hold counter <= 0.
  - PRESSED: hold counter, width $clog2(LONG_PRESS_CYCLES), increments each cycle.
    - When it reaches LONG_PRESS_CYCLES-1 -> HELD. `long_press_pulse` fires and `run` <= 0. This is LONG_PRESS_CYCLES cycles after `press_pulse`.
  - PRESSED -> IDLE on `btn_level` fall (short press). `release_pulse` fires and `run` <= ~`run` on the same edge.
  - HELD -> IDLE on `btn_level` fall. `release_pulse` fires; `run` unchanged.
- The hold counter saturates and never wraps; it is only reloaded on IDLE->PRESSED.
- Reset mid-press returns to IDLE with `run`=0. A button still held at reset release is then debounced normally and produces `press_pulse` after DEBOUNCE_CYCLES+3 edges (sync refill included).
- Illegal or unreachable encodings return to IDLE.

Optional Feature:
BTN_DEBOUNCE_LONG_PRESS_EN
- Defined: long-press detection as above; HELD state and hold counter present.
- Undefined: no hold counter, no HELD state. `long_press_pulse` is tied to 0. Every release toggles `run`, regardless of hold duration.

Decomposition:
- Package `btn_pkg`:
  - typedef enum logic [1:0] `btn_state_t` {IDLE, PRESSED, HELD};
  - localparam helper function for counter widths: max(1, $clog2(n)).
- Sub-module `sync_2ff`: parameterised reset value; reused by other async board inputs.
- FSM and counters stay in `btn_debounce`.

Test Plan:
- Bench parameters for all scenarios: DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16, ACTIVE_LOW=1.
- Clean press: `btn_in` 1->0 held 10 cycles -> `btn_level`=1 and `press_pulse` high for exactly one cycle, 5 edges after the first sampling edge.
- Bounce: `btn_in` toggles 0/1 every 2 cycles for 20 cycles, then back to 1 -> `btn_level` stays 0; no pulses.
- Short press: hold 8 cycles, release -> one `release_pulse`, `run` 0->1. Repeat -> `run` 1->0. `long_press_pulse` never fires.
- Long press with `run`=1: hold 30 cycles -> `long_press_pulse` 16 cycles after `press_pulse`, `run`=0. On release, `release_pulse` fires and `run` stays 0. With the macro undefined, the same stimulus gives `long_press_pulse`=0 and `run` toggles to 0 on release.
- Reset mid-press: assert `rst`=0 during PRESSED with `btn_in` held low -> next cycle all outputs 0, FSM IDLE. After `rst`=1, `press_pulse` fires 7 edges later.
